// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, FSM states and
// the helper that separates single-cycle from iterative operations.
package alu_mc_pkg;

  localparam int unsigned CTRL_CODE_W = 4;

  typedef enum logic [CTRL_CODE_W-1:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_MULLO = 4'b1000,
    OP_MULHI = 4'b1001,
    OP_DIVU  = 4'b1010,
    OP_REMU  = 4'b1011,
    OP_NOR   = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ITER = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // Codes 10xx are the bit-serial multiply/divide family.
  function automatic logic is_iter(input logic [CTRL_CODE_W-1:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_mc_muldiv_iter.sv
// Bit-serial unsigned multiply (shift-add) and divide (restoring) engine.
// Result sits in the 2*WIDTH accumulator: {hi, lo} = product or {remainder, quotient}.
module alu_mc_muldiv_iter
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             last_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic                   div_q;
  logic [WIDTH-1:0]       opnd_q;
  logic [2*WIDTH-1:0]     acc_q;
  logic [2*WIDTH-1:0]     acc_d;
  logic [CNT_W-1:0]       cnt_q;
  logic                   busy_q;
  logic                   last_q;

  logic [WIDTH-1:0]       hi_c;
  logic [WIDTH-1:0]       lo_c;
  logic [WIDTH-1:0]       diff_c;
  logic [WIDTH:0]         sum_c;
  logic [WIDTH:0]         rem_sh_c;

  assign hi_c = acc_q[2*WIDTH-1:WIDTH];
  assign lo_c = acc_q[WIDTH-1:0];

  // One iteration step; a zero divisor naturally yields all-ones quotient and remainder = a.
  always_comb begin
    sum_c    = {1'b0, hi_c} + (lo_c[0] ? {1'b0, opnd_q} : '0);
    rem_sh_c = {hi_c, lo_c[WIDTH-1]};
    diff_c   = WIDTH'(rem_sh_c - {1'b0, opnd_q});
    if (!div_q) begin
      acc_d = {sum_c, lo_c[WIDTH-1:1]};
    end else if (rem_sh_c >= {1'b0, opnd_q}) begin
      acc_d = {diff_c, lo_c[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {rem_sh_c[WIDTH-1:0], lo_c[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      last_q <= 1'b0;
    end else if (start_i) begin
      div_q  <= div_i;
      opnd_q <= div_i ? b_i : a_i;
      acc_q  <= {{WIDTH{1'b0}}, (div_i ? a_i : b_i)};
      cnt_q  <= CNT_W'(WIDTH - 1);
      busy_q <= 1'b1;
      last_q <= 1'b0;
    end else if (busy_q) begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_q - CNT_W'(1);
      last_q <= (cnt_q == CNT_W'(1));
      if (last_q) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_o = busy_q;
  assign last_o = last_q;
  assign lo_o   = lo_c;
  assign hi_o   = hi_c;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned mul/div,
// valid/ready accept and a registered result with a one-cycle done pulse.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CTRL_W = CTRL_CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  result,
  output logic              zero_flag,
  output logic              done
);

  state_e                 state_q;
  logic                   ready_q;
  logic [WIDTH-1:0]       result_q;
  logic                   zero_q;
  logic                   done_q;
  logic [CTRL_CODE_W-1:0] op_q;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;

  logic                   accept_c;
  logic                   iter_start_c;
  logic [WIDTH-1:0]       alu_c;
  logic [WIDTH-1:0]       iter_res_c;
  logic                   iter_busy;
  logic                   iter_last;
  logic [WIDTH-1:0]       iter_lo;
  logic [WIDTH-1:0]       iter_hi;

  assign accept_c     = valid_in && ready_q;
  assign iter_start_c = accept_c && is_iter(CTRL_CODE_W'(ctrl));

  alu_mc_muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (iter_start_c),
    .div_i   (ctrl[1]),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (iter_busy),
    .last_o  (iter_last),
    .lo_o    (iter_lo),
    .hi_o    (iter_hi)
  );

  // Single-cycle datapath on the captured operands; unknown codes give zero.
  always_comb begin
    alu_c = '0;
    case (op_q)
      OP_AND:  alu_c = a_q & b_q;
      OP_OR:   alu_c = a_q | b_q;
      OP_ADD:  alu_c = a_q + b_q;
      OP_SUB:  alu_c = a_q - b_q;
      OP_NOR:  alu_c = ~(a_q | b_q);
      OP_SLT:  alu_c = WIDTH'($signed(a_q) < $signed(b_q));
      default: alu_c = '0;
    endcase
  end

  // Odd iterative codes (MULHI, REMU) take the upper accumulator half.
  assign iter_res_c = op_q[0] ? iter_hi : iter_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      result_q <= '0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            op_q    <= CTRL_CODE_W'(ctrl);
            a_q     <= a;
            b_q     <= b;
            ready_q <= 1'b0;
            state_q <= iter_start_c ? ST_ITER : ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q <= alu_c;
          zero_q   <= (alu_c == '0);
          done_q   <= 1'b1;
          ready_q  <= 1'b1;
          state_q  <= ST_IDLE;
        end
        ST_ITER: begin
          if (iter_last) begin
            state_q <= ST_FIN;
          end else if (!iter_busy) begin
            ready_q <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_FIN: begin
          result_q <= iter_res_c;
          zero_q   <= (iter_res_c == '0);
          done_q   <= 1'b1;
          ready_q  <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready     = ready_q;
  assign result    = result_q;
  assign zero_flag = zero_q;
  assign done      = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed scoreboard bench for alu_mc at WIDTH=32 and WIDTH=8.
module tb_alu_mc;
  import alu_mc_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        v32, rdy32, z32, d32;
  logic [3:0]  c32;
  logic [31:0] a32, b32, r32;
  logic        v8, rdy8, z8, d8;
  logic [3:0]  c8;
  logic [7:0]  a8, b8, r8;

  int   nvec = 0;
  int   nerr = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32), .CTRL_W(4)) u_dut (
    .clk(clk), .rst(rst), .valid_in(v32), .ready(rdy32), .ctrl(c32),
    .a(a32), .b(b32), .result(r32), .zero_flag(z32), .done(d32)
  );

  alu_mc #(.WIDTH(8), .CTRL_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .valid_in(v8), .ready(rdy8), .ctrl(c8),
    .a(a8), .b(b8), .result(r8), .zero_flag(z8), .done(d8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model built from plain wide arithmetic.
  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input int w);
    longint unsigned m, xx, yy, p;
    longint sx, sy;
    m  = (64'd1 << w) - 64'd1;
    xx = {32'd0, x} & m;
    yy = {32'd0, y} & m;
    p  = xx * yy;
    sx = ((xx >> (w - 1)) != 0) ? longint'(xx) - longint'(m) - 1 : longint'(xx);
    sy = ((yy >> (w - 1)) != 0) ? longint'(yy) - longint'(m) - 1 : longint'(yy);
    case (op)
      4'b0000: return 32'(xx & yy);
      4'b0001: return 32'(xx | yy);
      4'b0010: return 32'((xx + yy) & m);
      4'b0110: return 32'((xx - yy) & m);
      4'b1100: return 32'(~(xx | yy) & m);
      4'b0111: return (sx < sy) ? 32'd1 : 32'd0;
      4'b1000: return 32'(p & m);
      4'b1001: return 32'((p >> w) & m);
      4'b1010: return (yy == 0) ? 32'(m) : 32'(xx / yy);
      4'b1011: return (yy == 0) ? 32'(xx) : 32'(xx % yy);
      default: return 32'd0;
    endcase
  endfunction

  // One 32-bit op: push expectation, accept, wait for done, check latency/result/hold.
  task automatic do_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input int lat, input bit hold);
    exp_t e;
    int   cyc;
    @(negedge clk);
    chk("ready_idle", 64'(rdy32), 64'd1);
    v32 = 1'b1; c32 = op; a32 = x; b32 = y;
    e.res = er; e.z = (er == 32'd0);
    sb.push_back(e);
    @(posedge clk); #1;
    if (!hold) v32 = 1'b0;
    a32 = $urandom; b32 = $urandom; c32 = 4'($urandom);
    cyc = 0;
    while (d32 !== 1'b1 && cyc < 100) begin
      chk("ready_busy", 64'(rdy32), 64'd0);
      @(posedge clk); #1;
      cyc++;
    end
    v32 = 1'b0;
    chk("latency", 64'(cyc), 64'(lat));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("result", 64'(r32), 64'(e.res));
      chk("zero_flag", 64'(z32), 64'(e.z));
    end
    chk("ready_at_done", 64'(rdy32), 64'd1);
    @(posedge clk); #1;
    chk("done_single", 64'(d32), 64'd0);
    chk("result_hold", 64'(r32), 64'(e.res));
  endtask

  task automatic do_op8(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input int lat);
    int cyc;
    @(negedge clk);
    v8 = 1'b1; c8 = op; a8 = x; b8 = y;
    @(posedge clk); #1;
    v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    cyc = 0;
    while (d8 !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("w8_latency", 64'(cyc), 64'(lat));
    chk("w8_result", 64'(r8), 64'(er));
    chk("w8_zero", 64'(z8), 64'(er == 8'd0));
  endtask

  initial begin
    logic [3:0]  ops[11];
    logic [31:0] ba[4];
    logic [31:0] bb[4];
    exp_t        e;
    int          idx, last, ndone;
    bit          saw_done;

    rst = 1'b1;
    v32 = 1'b0; c32 = '0; a32 = '0; b32 = '0;
    v8  = 1'b0; c8  = '0; a8  = '0; b8  = '0;
    #12;
    chk("rst_ready", 64'(rdy32), 64'd1);
    chk("rst_result", 64'(r32), 64'd0);
    chk("rst_zero", 64'(z32), 64'd1);
    chk("rst_done", 64'(d32), 64'd0);
    chk("rst_ready8", 64'(rdy8), 64'd1);
    #10 rst = 1'b0;

    do_op(OP_ADD, 32'd1200, 32'd9999, 32'd11199, 1, 1'b0);
    do_op(OP_SUB, 32'h1234, 32'h1234, 32'd0, 1, 1'b0);
    do_op(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1'b0);
    do_op(OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    do_op(OP_NOR, 32'h0F0F_0000, 32'h00F0_0000, 32'h F000_FFFF, 1, 1'b0);
    do_op(OP_MULLO, 32'd1000000, 32'd1231233, 32'd2872353344, 33, 1'b0);
    do_op(OP_MULHI, 32'd1000000, 32'd1231233, 32'd286, 33, 1'b1);
    do_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    do_op(OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b1);
    do_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 33, 1'b0);
    do_op(OP_REMU, 32'd5, 32'd0, 32'd5, 33, 1'b0);
    do_op(4'b0011, 32'd77, 32'd88, 32'd0, 1, 1'b0);
    do_op(OP_MULHI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);

    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_SLT,
            OP_MULLO, OP_MULHI, OP_DIVU, OP_REMU, 4'b1111};
    for (int i = 0; i < 16; i++) begin
      logic [3:0]  op;
      logic [31:0] x, y;
      op = ops[$urandom_range(0, 10)];
      x  = $urandom;
      y  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      do_op(op, x, y, model(op, x, y, 32), is_iter(op) ? 33 : 1, 1'(i % 2));
    end

    // Back-to-back ADDs with valid held high: one done every 2 cycles.
    ba = '{32'd10, 32'd20, 32'd30, 32'hFFFF_FFFF};
    bb = '{32'd1, 32'd2, 32'd3, 32'd1};
    @(negedge clk);
    idx = 0; last = -1; ndone = 0;
    v32 = 1'b1; c32 = OP_ADD; a32 = ba[0]; b32 = bb[0];
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (v32 && rdy32) begin
        e.res = ba[idx] + bb[idx];
        e.z   = (e.res == 32'd0);
        sb.push_back(e);
        idx++;
      end
      @(posedge clk); #1;
      if (d32 === 1'b1 && sb.size() > 0) begin
        e = sb.pop_front();
        chk("b2b_result", 64'(r32), 64'(e.res));
        chk("b2b_zero", 64'(z32), 64'(e.z));
        if (last >= 0) chk("b2b_gap", 64'(cyc - last), 64'd2);
        last = cyc;
        ndone++;
      end
      if (idx < 4) begin
        a32 = ba[idx]; b32 = bb[idx];
      end else begin
        v32 = 1'b0;
      end
    end
    chk("b2b_count", 64'(ndone), 64'd4);

    // Reset in the middle of a multiply aborts it.
    do_op(OP_ADD, 32'd5, 32'd6, 32'd11, 1, 1'b0);
    @(negedge clk);
    v32 = 1'b1; c32 = OP_MULLO; a32 = 32'd1000; b32 = 32'd3000;
    @(posedge clk); #1;
    v32 = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", 64'(rdy32), 64'd1);
    chk("abort_result", 64'(r32), 64'd0);
    chk("abort_zero", 64'(z32), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (d32 === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    chk("abort_ready_after", 64'(rdy32), 64'd1);
    chk("abort_result_after", 64'(r32), 64'd0);

    // Narrow instance.
    do_op8(OP_MULLO, 8'd200, 8'd2, 8'd144, 9);
    do_op8(OP_MULHI, 8'd200, 8'd2, 8'd1, 9);
    do_op8(OP_DIVU, 8'd200, 8'd0, 8'hFF, 9);
    do_op8(OP_ADD, 8'd200, 8'd56, 8'd0, 1);
    do_op8(OP_SLT, 8'h80, 8'h7F, 8'd1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, the successor to the single-cycle `Alu32`. It keeps the same 4-bit operation encoding and zero flag, generalises the datapath to `WIDTH` bits, and adds iterative unsigned multiply and divide. Operations are accepted through a valid/ready handshake, and the result is registered with a one-cycle `done` pulse. It sits in the execute stage of the multi-cycle processor variant, where the control FSM stalls on `ready`.

## Interface
- `WIDTH`, 32, operand/result width; legal range ≥ 4.
- `CTRL_W`, 4, operation code width; fixed encoding, not to be changed.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  operation request.
- `ready`  out  1  high when idle and able to accept.
- `ctrl`  in  CTRL_W  operation code, sampled on accept.
- `a`, `b`  in  WIDTH  operands, sampled on accept.
- `result`  out  WIDTH  registered result; holds until the next `done`.
- `zero_flag`  out  1  `result == 0`; updated with `result`.
- `done`  out  1  one-cycle pulse, coincident with the new `result`.

## Operation
- Accept: `valid_in && ready` on a rising edge. `a`, `b` and `ctrl` are captured; callers do not need to hold them afterwards.
- Single-cycle codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR.
  - 0111 SLT: signed compare, result is 1 or 0, zero-extended.
  - ADD and SUB wrap modulo 2^WIDTH; no overflow output.
- Iterative codes (one bit per cycle):
  - 1000 MULLO: low WIDTH bits of the unsigned product (shift-add).
  - 1001 MULHI: high WIDTH bits of the unsigned product.
  - 1010 DIVU: unsigned quotient (restoring division).
  - 1011 REMU: unsigned remainder (restoring division).
- Divide by zero: DIVU returns all ones; REMU returns `a`. No exception is raised.
- Any other code: `result` = 0, `zero_flag` = 1, handled as single-cycle.
- FSM states:
  - IDLE: `ready` = 1. On accept, go to EXEC for a single-cycle code, or ITER with counter = WIDTH-1 for an iterative code.
  - EXEC: writes `result`, pulses `done`, returns to IDLE.
  - ITER: one step per cycle; counter decrements. When counter = 0, go to FIN.
  - FIN: writes `result`, pulses `done`, returns to IDLE.
- `valid_in` while `ready` = 0 is ignored. No queueing; the request must be re-presented.
- Reset values: state IDLE, `ready` = 1, `result` = 0, `zero_flag` = 1, `done` = 0, internal accumulators 0.
- Reset asserted mid-ITER aborts the operation: no `done` pulse, outputs return to reset values.

## Timing
- Single-cycle ops: accept at edge N, then `done` and `result` valid after edge N+1. Latency 1; `ready` is low for 1 cycle.
- Iterative ops: accept at edge N, then `done` after edge N+WIDTH+1. Latency WIDTH+1 (33 at `WIDTH` = 32); `ready` is low for WIDTH+1 cycles.
- `ready` rises in the same cycle as `done`. A new accept is therefore possible on the edge that ends the `done` cycle, giving a back-to-back throughput of one single-cycle op every 2 cycles.
- `done` is never asserted for two consecutive cycles.
- `result` and `zero_flag` change only in the `done` cycle or on reset.

## Structure
- Shared header `alu_defs.vh` holds:
  - all `ctrl` code constants, which `Alu32` must also use;
  - the FSM state encodings.
- One sub-module, `alu_muldiv_iter`:
  - holds the shared WIDTH-bit shift register, the 2·WIDTH-bit accumulator and the counter;
  - is selected between multiply and divide modes;
  - exposes `start`, `busy` and `last`.
- Top level: the single-cycle datapath, the FSM and the output registers.

## Test plan
- ADD `a` = 1200, `b` = 9999 -> `result` = 11199, `zero_flag` = 0, `done` one cycle after accept.
- SUB `a` = `b` = 0x1234 -> `result` = 0, `zero_flag` = 1. SLT `a` = 0xFFFFFFFF, `b` = 1 -> `result` = 1.
- MULLO / MULHI `a` = 1000000, `b` = 1231233 -> 2872353344 / 286. `done` exactly 33 cycles after accept; `ready` = 0 throughout.
- DIVU / REMU 100/7 -> 14 / 2. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- `valid_in` held high during ITER -> no second accept. Back-to-back ADDs -> one `done` every 2 cycles.
- `rst` pulsed at cycle 10 of a MULLO -> no `done`; `ready` = 1, `result` = 0, `zero_flag` = 1. Repeat with `WIDTH` = 8: 200×2 MULLO -> 144, MULHI -> 1, latency 9.
